// File: rtl/gt_pack_telemetry.sv
// Transmit-side framer for the GT telemetry link: packs 88-bit packets into
// SOP/D1/D0/EOP words with comma idles between frames, CRC-8 and sequence number.
module gt_pack_telemetry #(
    parameter int IDLE_MIN = 1
) (
    input  logic        clk_128M,
    input  logic        rst_128M,
    input  logic        enable,
    input  logic [87:0] packet_data,
    input  logic        packet_valid,
    output logic        packet_ready,
    output logic [31:0] gt_data,
    output logic [3:0]  gt_data_is_k,
    output logic [31:0] frames_sent
);

    localparam logic [7:0]  K_SOP     = 8'hFB;
    localparam logic [7:0]  K_EOP     = 8'hFD;
    localparam logic [31:0] IDLE_WORD = 32'h50BC50BC;
    localparam logic [3:0]  IDLE_K    = 4'b0101;

    typedef enum logic [2:0] {S_IDLE, S_SOP, S_D1, S_D0, S_EOP} state_t;

    state_t       state_reg;
    logic [7:0]   idle_cnt_reg;
    logic [87:0]  hold_reg;
    logic [7:0]   crc_reg;
    logic [15:0]  seq_reg;
    logic [31:0]  frames_reg;
    logic [31:0]  gt_data_reg;
    logic [3:0]   gt_k_reg;
    logic         accept;

    // CRC-8, poly 0x07, init 0, MSB-first over byte 10 down to byte 0.
    function automatic logic [7:0] crc8(input logic [87:0] d);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 87; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    assign packet_ready = (state_reg == S_IDLE) && (idle_cnt_reg >= 8'(IDLE_MIN)) && enable;
    assign accept       = packet_valid && packet_ready;

    always_ff @(posedge clk_128M) begin
        if (rst_128M) begin
            state_reg    <= S_IDLE;
            idle_cnt_reg <= 8'd0;
            hold_reg     <= '0;
            crc_reg      <= 8'h00;
            seq_reg      <= 16'd0;
            frames_reg   <= 32'd0;
            gt_data_reg  <= IDLE_WORD;
            gt_k_reg     <= IDLE_K;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        state_reg    <= S_SOP;
                        hold_reg     <= packet_data;
                        idle_cnt_reg <= 8'd0;
                        gt_data_reg  <= {packet_data[87:64], K_SOP};
                        gt_k_reg     <= 4'b0001;
                    end else begin
                        idle_cnt_reg <= (idle_cnt_reg == 8'hFF) ? 8'hFF : idle_cnt_reg + 8'd1;
                        gt_data_reg  <= IDLE_WORD;
                        gt_k_reg     <= IDLE_K;
                    end
                end
                S_SOP: begin
                    // CRC is taken from the holding register so the input bus is free after accept.
                    state_reg   <= S_D1;
                    crc_reg     <= crc8(hold_reg);
                    gt_data_reg <= hold_reg[63:32];
                    gt_k_reg    <= 4'b0000;
                end
                S_D1: begin
                    state_reg   <= S_D0;
                    gt_data_reg <= hold_reg[31:0];
                    gt_k_reg    <= 4'b0000;
                end
                S_D0: begin
                    state_reg   <= S_EOP;
                    gt_data_reg <= {seq_reg, crc_reg, K_EOP};
                    gt_k_reg    <= 4'b0001;
                end
                S_EOP: begin
                    // The first idle cycle after EOP already counts toward the gap.
                    state_reg    <= S_IDLE;
                    idle_cnt_reg <= 8'd1;
                    seq_reg      <= seq_reg + 16'd1;
                    frames_reg   <= frames_reg + 32'd1;
                    gt_data_reg  <= IDLE_WORD;
                    gt_k_reg     <= IDLE_K;
                end
                default: begin
                    state_reg    <= S_IDLE;
                    idle_cnt_reg <= 8'd0;
                    gt_data_reg  <= IDLE_WORD;
                    gt_k_reg     <= IDLE_K;
                end
            endcase
        end
    end

    assign gt_data      = gt_data_reg;
    assign gt_data_is_k = gt_k_reg;
    assign frames_sent  = frames_reg;

endmodule

// File: tb/tb_gt_pack_telemetry.sv
// Directed bench for gt_pack_telemetry: two instances (IDLE_MIN = 1 and 3) on one clock,
// one line per transaction, single summary line at the end.
module tb_gt_pack_telemetry;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en0 = 1'b1;
    logic        pv [2];
    logic [87:0] pd [2];
    wire         pr [2];
    wire  [31:0] gd [2];
    wire  [3:0]  gk [2];
    wire  [31:0] fs [2];

    wire         pr_a, pr_b;
    wire  [31:0] gd_a, gd_b, fs_a, fs_b;
    wire  [3:0]  gk_a, gk_b;

    assign pr[0] = pr_a;  assign pr[1] = pr_b;
    assign gd[0] = gd_a;  assign gd[1] = gd_b;
    assign gk[0] = gk_a;  assign gk[1] = gk_b;
    assign fs[0] = fs_a;  assign fs[1] = fs_b;

    always #4 clk = ~clk;

    gt_pack_telemetry #(.IDLE_MIN(1)) dut_a (
        .clk_128M(clk), .rst_128M(rst), .enable(en0),
        .packet_data(pd[0]), .packet_valid(pv[0]), .packet_ready(pr_a),
        .gt_data(gd_a), .gt_data_is_k(gk_a), .frames_sent(fs_a)
    );

    gt_pack_telemetry #(.IDLE_MIN(3)) dut_b (
        .clk_128M(clk), .rst_128M(rst), .enable(1'b1),
        .packet_data(pd[1]), .packet_valid(pv[1]), .packet_ready(pr_b),
        .gt_data(gd_b), .gt_data_is_k(gk_b), .frames_sent(fs_b)
    );

    int n_vec = 0;
    int n_bad = 0;
    logic [87:0] pl [16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Byte-wise, bit-serial CRC-8/0x07 reference.
    function automatic logic [7:0] crc_model(input logic [87:0] d);
        logic [7:0] c;
        logic [7:0] by;
        logic       fb;
        c = 8'h00;
        for (int b = 10; b >= 0; b--) begin
            by = d[b*8 +: 8];
            for (int j = 7; j >= 0; j--) begin
                fb = c[7] ^ by[j];
                c  = {c[6:0], 1'b0};
                if (fb) c = c ^ 8'h07;
            end
        end
        return c;
    endfunction

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_ready();
        int w = 0;
        while (pr[0] !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("ready_wait", {63'd0, pr[0]}, 64'd1);
    endtask

    task automatic send_frame(input logic [87:0] d, input logic [15:0] sq, input logic [31:0] fs_exp);
        wait_ready();
        pv[0] = 1'b1;
        pd[0] = d;
        @(negedge clk);
        pv[0] = 1'b0;
        pd[0] = ~d;
        chk("sop", {gk[0], gd[0]}, {4'b0001, d[87:64], 8'hFB});
        @(negedge clk);
        chk("d1", {gk[0], gd[0]}, {4'b0000, d[63:32]});
        @(negedge clk);
        chk("d0", {gk[0], gd[0]}, {4'b0000, d[31:0]});
        @(negedge clk);
        chk("eop", {gk[0], gd[0]}, {4'b0001, sq, crc_model(d), 8'hFD});
        @(negedge clk);
        chk("post_idle", {gk[0], gd[0]}, {4'b0101, 32'h50BC50BC});
        chk("frames", fs[0], fs_exp);
    endtask

    task automatic drive_run(input int k);
        int   idx   = 0;
        int   guard = 0;
        logic acc;
        pv[k] = 1'b1;
        pd[k] = pl[0];
        acc   = pr[k];
        while (idx < 10 && guard < 200) begin
            @(negedge clk);
            guard++;
            if (acc) idx++;
            if (idx < 10) begin
                pd[k] = pl[idx];
                acc   = pr[k];
            end
        end
        pv[k] = 1'b0;
        chk($sformatf("drv%0d_accepts", k), idx, 10);
    endtask

    task automatic mon_run(input int k, input int period, input int ncyc);
        int last = -1;
        int sopc = -1;
        int n    = 0;
        int m;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            m = (n < 15) ? n : 15;
            if (gk[k] == 4'b0001 && gd[k][7:0] == 8'hFB) begin
                if (last >= 0) chk($sformatf("m%0d_sop_gap", k), c - last, period);
                last = c;
                sopc = c;
                chk($sformatf("m%0d_sop%0d", k, n), gd[k][31:8], pl[m][87:64]);
            end else if (sopc >= 0 && c == sopc + 1) begin
                chk($sformatf("m%0d_d1_%0d", k, n), gd[k], pl[m][63:32]);
            end else if (sopc >= 0 && c == sopc + 2) begin
                chk($sformatf("m%0d_d0_%0d", k, n), gd[k], pl[m][31:0]);
            end else if (gk[k] == 4'b0001 && gd[k][7:0] == 8'hFD) begin
                chk($sformatf("m%0d_eop%0d", k, n), gd[k], {n[15:0], crc_model(pl[m]), 8'hFD});
                n++;
            end
        end
        chk($sformatf("m%0d_nframes", k), n, 10);
    endtask

    initial begin
        int cnt;
        pv[0] = 1'b0; pv[1] = 1'b0;
        pd[0] = '0;   pd[1] = '0;
        for (int i = 0; i < 16; i++)
            pl[i] = {11{8'(8'h10 + i)}} ^ 88'h0123456789ABCDEF012345;

        // Reset then idle
        repeat (3) @(negedge clk);
        chk("rst_ready", {63'd0, pr[0]}, 64'd0);
        chk("rst_word", {gk[0], gd[0]}, {4'b0101, 32'h50BC50BC});
        chk("rst_frames", fs[0], 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_release", {63'd0, pr[0]}, 64'd1);
        chk("frames_after_release", fs[0], 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("idle_word", {gk[0], gd[0]}, {4'b0101, 32'h50BC50BC});
        end

        // Zero payload, then known payload
        send_frame(88'h0, 16'd0, 32'd1);
        send_frame(88'h0102030405060708090A0B, 16'd1, 32'd2);

        // Continuous valid on both instances
        do_reset(2);
        fork
            drive_run(0);
            drive_run(1);
            mon_run(0, 5, 85);
            mon_run(1, 7, 85);
        join

        // Enable drop mid-frame with valid held high
        do_reset(2);
        wait_ready();
        pv[0] = 1'b1;
        pd[0] = pl[3];
        @(negedge clk);
        chk("bp_sop_a", {gk[0], gd[0]}, {4'b0001, pl[3][87:64], 8'hFB});
        pd[0] = pl[4];
        chk("bp_ready_sop", {63'd0, pr[0]}, 64'd0);
        @(negedge clk);
        chk("bp_d1_a", gd[0], pl[3][63:32]);
        en0 = 1'b0;
        @(negedge clk);
        chk("bp_d0_a", gd[0], pl[3][31:0]);
        chk("bp_ready_d0", {63'd0, pr[0]}, 64'd0);
        @(negedge clk);
        chk("bp_eop_a", gd[0], {16'd0, crc_model(pl[3]), 8'hFD});
        repeat (4) begin
            @(negedge clk);
            chk("bp_idle_word", {gk[0], gd[0]}, {4'b0101, 32'h50BC50BC});
            chk("bp_ready_low", {63'd0, pr[0]}, 64'd0);
        end
        en0 = 1'b1;
        #1;
        chk("bp_ready_back", {63'd0, pr[0]}, 64'd1);
        @(negedge clk);
        pv[0] = 1'b0;
        chk("bp_sop_b", {gk[0], gd[0]}, {4'b0001, pl[4][87:64], 8'hFB});
        @(negedge clk);
        chk("bp_d1_b", gd[0], pl[4][63:32]);
        @(negedge clk);
        chk("bp_d0_b", gd[0], pl[4][31:0]);
        @(negedge clk);
        chk("bp_eop_b", gd[0], {16'd1, crc_model(pl[4]), 8'hFD});
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (gk[0] == 4'b0001 && gd[0][7:0] == 8'hFB) cnt++;
        end
        chk("bp_no_dup_sop", cnt, 0);
        chk("bp_frames", fs[0], 32'd2);

        // Reset while in S_D0
        do_reset(2);
        wait_ready();
        pv[0] = 1'b1;
        pd[0] = pl[5];
        @(negedge clk);
        pv[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mr_d0", gd[0], pl[5][31:0]);
        rst = 1'b1;
        @(negedge clk);
        chk("mr_idle", {gk[0], gd[0]}, {4'b0101, 32'h50BC50BC});
        chk("mr_frames", fs[0], 32'd0);
        rst = 1'b0;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (gk[0][0] && gd[0][7:0] == 8'hFD) cnt++;
        end
        chk("mr_no_eop", cnt, 0);
        send_frame(pl[6], 16'd0, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
